// File: rtl/dec_3to8_pkg.sv
// Shared types and widths for the registered 3-to-8 pulse decoder.
// Holds the FSM state enum and the code/bus/counter widths.
package dec_3to8_pkg;

    localparam int CODE_W = 3;
    localparam int OUT_W  = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/decoder_3to8_pulse_onehot.sv
// Purely combinational 3-to-8 one-hot decode.
// Ports: i_code (binary index), o_onehot (exactly one bit set).
module onehot_dec3
    import dec_3to8_pkg::*;
(
    input  logic [CODE_W-1:0] i_code,
    output logic [OUT_W-1:0]  o_onehot
);

    assign o_onehot = OUT_W'(1) << i_code;

endmodule

// File: rtl/decoder_3to8_pulse.sv
// Registered 3-to-8 decoder: accepts a code on valid/ready, drives its
// one-hot line for PULSE_LEN cycles, then idles GAP_LEN cycles.
// Ports: clk, rst (sync, active high), in_valid/in_ready/in_code handshake,
// in_par (odd parity, only with DEC_3TO8_PARITY_EN), out (one-hot strobe),
// out_valid (out non-zero), done (last pulse cycle), err (rejected code).
// Optional feature macro: DEC_3TO8_PARITY_EN.
module decoder_3to8_pulse
    import dec_3to8_pkg::*;
#(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
`ifdef DEC_3TO8_PARITY_EN
    input  logic              in_par,
`endif
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_CNT   =
        (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [OUT_W-1:0]   r_out;
    logic [OUT_W-1:0]   w_out_nxt;
    logic [OUT_W-1:0]   w_onehot;
    logic               w_hs;
    logic               w_par_ok;

    onehot_dec3 u_dec (
        .i_code   (in_code),
        .o_onehot (w_onehot)
    );

    assign w_hs = in_valid && (r_state == IDLE);

`ifdef DEC_3TO8_PARITY_EN
    logic r_err;

    // Odd parity over {in_par, in_code} marks a good code.
    assign w_par_ok = ^{in_par, in_code};

    // A bad code is still consumed; it only raises err for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_hs && !w_par_ok;
        end
    end

    assign err = r_err;
`else
    assign w_par_ok = 1'b1;
    assign err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        case (r_state)
            IDLE: begin
                if (w_hs && w_par_ok) begin
                    w_out_nxt   = w_onehot;
                    w_cnt_nxt   = PULSE_CNT;
                    w_state_nxt = PULSE;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_out_nxt = '0;
                    if (GAP_LEN > 0) begin
                        w_cnt_nxt   = GAP_CNT;
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_out_nxt   = '0;
            end
        endcase
    end

    assign out       = r_out;
    assign out_valid = (r_state == PULSE);
    assign done      = (r_state == PULSE) && (r_cnt == '0);
    assign in_ready  = (r_state == IDLE);

endmodule

// File: tb/tb_decoder_3to8_pulse.sv
// Bench for decoder_3to8_pulse: two instances (4/1 and 1/0 timing)
// checked every cycle against a time-stamp model plus literal pins.
module tb_decoder_3to8_pulse;

    localparam int P0 = 4;
    localparam int G0 = 1;
    localparam int P1 = 1;
    localparam int G1 = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;
`ifdef DEC_3TO8_PARITY_EN
    logic       in_par = 1'b1;
`endif

    logic [7:0] o_out [2];
    logic       o_rdy [2];
    logic       o_ov  [2];
    logic       o_done[2];
    logic       o_err [2];

    always #5 clk = ~clk;

    decoder_3to8_pulse #(.PULSE_LEN(P0), .GAP_LEN(G0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (o_rdy[0]),
        .in_code   (in_code),
`ifdef DEC_3TO8_PARITY_EN
        .in_par    (in_par),
`endif
        .out       (o_out[0]),
        .out_valid (o_ov[0]),
        .done      (o_done[0]),
        .err       (o_err[0])
    );

    decoder_3to8_pulse #(.PULSE_LEN(P1), .GAP_LEN(G1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (o_rdy[1]),
        .in_code   (in_code),
`ifdef DEC_3TO8_PARITY_EN
        .in_par    (in_par),
`endif
        .out       (o_out[1]),
        .out_valid (o_ov[1]),
        .done      (o_done[1]),
        .err       (o_err[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
        end
    endtask

    // Model: remember the edge index of the last accepted code; every
    // output is a function of how many cycles have elapsed since then.
    int         pl[2] = '{P0, P1};
    int         gl[2] = '{G0, G1};
    int         cyc = 0;
    bit         seen = 1'b0;
    bit         act[2] = '{1'b0, 1'b0};
    int         last[2] = '{0, 0};
    logic [2:0] mcode[2] = '{3'd0, 3'd0};
    bit         err_e[2] = '{1'b0, 1'b0};

    function automatic bit m_ready(int m, int at);
        return !act[m] || (at - last[m] >= pl[m] + gl[m]);
    endfunction

    initial forever begin
        bit ok;
        @(posedge clk);
        cyc++;
`ifdef DEC_3TO8_PARITY_EN
        ok = ^{in_par, in_code};
`else
        ok = 1'b1;
`endif
        for (int m = 0; m < 2; m++) begin
            err_e[m] = 1'b0;
            if (rst) begin
                act[m] = 1'b0;
                seen   = 1'b1;
            end else if (seen && in_valid && m_ready(m, cyc - 1)) begin
                if (ok) begin
                    act[m]   = 1'b1;
                    last[m]  = cyc;
                    mcode[m] = in_code;
                end else begin
                    err_e[m] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (seen) begin
            for (int m = 0; m < 2; m++) begin
                int         j;
                logic [7:0] eo;
                j  = cyc - last[m];
                eo = (act[m] && j < pl[m]) ? (8'(1) << mcode[m]) : 8'h00;
                chk($sformatf("out%0d", m), o_out[m], eo);
                chk($sformatf("ov%0d", m), o_ov[m], eo != 8'h00);
                chk($sformatf("done%0d", m), o_done[m],
                    act[m] && (j == pl[m] - 1));
                chk($sformatf("rdy%0d", m), o_rdy[m], m_ready(m, cyc));
                chk($sformatf("err%0d", m), o_err[m], err_e[m]);
                chk($sformatf("onehot%0d", m), $countones(o_out[m]) <= 1,
                    1'b1);
            end
        end
    end

    task automatic set_code(input logic [2:0] c);
        in_code = c;
`ifdef DEC_3TO8_PARITY_EN
        in_par = ~^c;
`endif
    endtask

    // Called at a negedge; returns at a negedge where dut0 is ready.
    task automatic wait_ready();
        int g = 0;
        while (!o_rdy[0] && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("ready_wait", o_rdy[0], 1'b1);
    endtask

    // Returns at the negedge right after the accepting edge.
    task automatic send(input logic [2:0] c);
        set_code(c);
        in_valid = 1'b1;
        wait_ready();
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out", o_out[0], 8'h00);
        chk("rst_rdy", o_rdy[0], 1'b1);

        send(3'd5);
        in_valid = 1'b0;
        chk("c5_out", o_out[0], 8'h20);
        chk("c5_ov", o_ov[0], 1'b1);
        repeat (3) @(negedge clk);
        chk("c5_done", o_done[0], 1'b1);
        chk("c5_out3", o_out[0], 8'h20);
        @(negedge clk);
        chk("c5_gap", o_out[0], 8'h00);
        chk("c5_gaprdy", o_rdy[0], 1'b0);
        @(negedge clk);
        chk("c5_rdy", o_rdy[0], 1'b1);

        for (int c = 0; c < 8; c++) begin
            send(3'(c));
            chk("sweep", o_out[0], 8'(1) << c);
        end
        in_valid = 1'b0;

        send(3'd2);
        set_code(3'd6);
        @(negedge clk);
        chk("hold2_a", o_out[0], 8'h04);
        @(negedge clk);
        chk("hold2_b", o_out[0], 8'h04);
        wait_ready();
        @(negedge clk);
        chk("late6", o_out[0], 8'h40);
        in_valid = 1'b0;

        send(3'd7);
        in_valid = 1'b0;
        chk("c7_out", o_out[0], 8'h80);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_out", o_out[0], 8'h00);
        chk("mid_rst_ov", o_ov[0], 1'b0);
        chk("mid_rst_done", o_done[0], 1'b0);
        chk("mid_rst_rdy", o_rdy[0], 1'b1);

        set_code(3'd3);
        in_valid = 1'b1;
        @(negedge clk);
        chk("p1_out", o_out[1], 8'h08);
        chk("p1_done", o_done[1], 1'b1);
        @(negedge clk);
        chk("p1_idle", o_out[1], 8'h00);
        chk("p1_rdy", o_rdy[1], 1'b1);
        @(negedge clk);
        chk("p1_again", o_out[1], 8'h08);
        in_valid = 1'b0;

`ifdef DEC_3TO8_PARITY_EN
        wait_ready();
        in_code  = 3'd1;
        in_par   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("par_ok_out", o_out[0], 8'h02);
        wait_ready();
        in_code  = 3'd1;
        in_par   = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("par_bad_err", o_err[0], 1'b1);
        chk("par_bad_out", o_out[0], 8'h00);
        chk("par_bad_rdy", o_rdy[0], 1'b1);
        @(negedge clk);
        chk("par_err_end", o_err[0], 1'b0);
`endif

        repeat (800) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 2) != 0);
            in_code  = 3'($urandom_range(0, 7));
`ifdef DEC_3TO8_PARITY_EN
            in_par   = 1'($urandom_range(0, 1));
`endif
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decoder_3to8_pulse.md
# decoder_3to8_pulse

Registered 3-to-8 decoder with handshake and timed strobe output: the decode-side counterpart to the 8-to-3 encoder. Accepts a 3-bit code on a valid/ready handshake and drives the matching one-hot line of an 8-bit strobe bus for a programmable number of cycles, then enforces a programmable idle gap before accepting the next code. Sits between a code-issuing controller and eight downstream select/enable lines that need clean, glitch-free, fixed-width pulses.

## Interface
Parameters:
- PULSE_LEN, 4: cycles each one-hot strobe is held; legal range 1..255.
- GAP_LEN, 1: all-zero cycles after each strobe before in_ready returns; legal range 0..255.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_code is valid this cycle.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  3  binary index of the line to strobe.
- in_par  input  1  odd-parity bit over in_code; present only with DEC_3TO8_PARITY_EN.
- out  output  8  one-hot strobe bus; bit in_code set during pulse, all-zero otherwise.
- out_valid  output  1  high exactly while out is non-zero.
- done  output  1  high in the last pulse cycle of each strobe.
- err  output  1  one-cycle pulse on a rejected code (parity build only; constant 0 otherwise).

## Operation
- States: IDLE, PULSE, GAP. Down-counter cnt, width 8.
- IDLE: in_ready=1, out=0. Handshake = in_valid && in_ready. On handshake: register one-hot(in_code) into out, cnt<=PULSE_LEN-1, go PULSE.
- PULSE: in_ready=0, out held, out_valid=1. cnt==0: done=1 this cycle; at edge clear out; go GAP with cnt<=GAP_LEN-1 if GAP_LEN>0, else IDLE. Otherwise cnt decrements.
- GAP: out=0, in_ready=0. cnt==0 -> IDLE; else decrement.
- in_valid while in_ready=0 is ignored; the source must hold in_code/in_valid until handshake.
- in_code out of range cannot occur (3 bits map to 8 lines); out never has more than one bit set.
- Reset values: state IDLE, out=8'h00, out_valid=0, done=0, err=0, cnt=0; in_ready=1 from the first cycle after reset.
- Reset mid-PULSE or mid-GAP: out cleared and IDLE at that same edge; the pending strobe is abandoned, no done.

## Timing
- Handshake sampled at edge E0; out/out_valid high from E0 through E0+PULSE_LEN (PULSE_LEN cycles); done in the final one.
- in_ready low from E0 until E0+PULSE_LEN+GAP_LEN; next handshake earliest at that edge.
- Max throughput: one code per 1+PULSE_LEN+GAP_LEN cycles.
- All outputs registered or decoded from state only; no combinational path from in_valid/in_code to any output.

## Configuration
- DEC_3TO8_PARITY_EN defined: in_par port exists. At handshake, if ^{in_par,in_code}==0 (even, invalid) the code is consumed but rejected: err=1 for one cycle after E0, out stays 0, state stays IDLE, in_ready stays 1. Valid parity proceeds normally, err=0.
- Not defined: in_par port absent, no parity logic, err tied 0, every handshake produces a strobe.

## Structure
- Shared package dec_3to8_pkg: state enum typedef (IDLE/PULSE/GAP), CODE_W=3, OUT_W=8, CNT_W=8 constants.
- One natural sub-module: onehot_dec3, purely combinational 3-to-8 one-hot decode, instanced ahead of the out register. Counter and FSM stay in the top.

## Test plan
- Reset release, defaults: in_code=3'd5 single handshake -> out=8'h20, out_valid=1 for exactly 4 cycles, done in 4th, then 1 zero cycle, in_ready back at cycle 6.
- Sweep codes 0..7 back-to-back with in_valid held high -> outputs 8'h01,02,04,...,80 in order, each 4 cycles wide, separated by 1 zero cycle plus 1 IDLE cycle; never two bits set.
- PULSE_LEN=1, GAP_LEN=0: continuous in_valid, code 3 -> out=8'h08 one cycle, done same cycle, next accept after 2-cycle period.
- in_valid asserted with code 6 during PULSE of code 2 -> no change to out=8'h04; code 6 strobe starts only after in_ready returns.
- rst asserted in second PULSE cycle of code 7 -> next cycle out=8'h00, out_valid=0, done never seen, in_ready=1.
- Parity build: in_code=3'd1, in_par=0 (valid) -> out=8'h02; in_code=3'd1, in_par=1 -> err one cycle, out stays 8'h00, in_ready stays 1.
